// File: rtl/ind_port_seq.sv
// Table-driven sequencer for one independent pulse port: steps through stored
// pulse configurations, firing a one-cycle enable per entry. Optional external
// trigger arming is enabled by defining IND_PORT_SEQ_EXT_TRIG_EN.
module ind_port_seq #(
  parameter int unsigned RAM_WIDTH = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ADDR_W    = 3
) (
  input  logic                 io_clk,
  input  logic                 io_rst_n,
`ifdef IND_PORT_SEQ_EXT_TRIG_EN
  input  logic                 io_ext_trig,
`endif
  input  logic                 io_wr_en,
  input  logic [ADDR_W-1:0]    io_wr_addr,
  input  logic [RAM_WIDTH-1:0] io_wr_width,
  input  logic [RAM_WIDTH-1:0] io_wr_delay,
  input  logic [15:0]          io_wr_repeat,
  input  logic [RAM_WIDTH-1:0] io_wr_dwell,
  input  logic [ADDR_W:0]      io_num_entries,
  input  logic                 io_start,
  input  logic                 io_abort,
  input  logic                 io_loop,
  output logic                 io_pulseEn,
  output logic [RAM_WIDTH-1:0] io_pulseWidth,
  output logic [RAM_WIDTH-1:0] io_trigDelay,
  output logic [15:0]          io_repeatCnt,
  output logic                 io_busy,
  output logic [ADDR_W-1:0]    io_cur_idx,
  output logic                 io_done,
  output logic [15:0]          io_pass_cnt
);

  localparam int unsigned          TBL     = 1 << ADDR_W;
  localparam logic [ADDR_W:0]      DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [RAM_WIDTH-1:0] CNT_ONE = {{(RAM_WIDTH-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [RAM_WIDTH-1:0] width;
    logic [RAM_WIDTH-1:0] delay;
    logic [15:0]          rep;
    logic [RAM_WIDTH-1:0] dwell;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef IND_PORT_SEQ_EXT_TRIG_EN
    S_ARM,
`endif
    S_FIRE,
    S_DWELL,
    S_DONE
  } state_t;

  entry_t               tbl_q [TBL];
  state_t               state_q, state_d;
  logic                 start_q;
  logic [ADDR_W-1:0]    idx_q, idx_d;
  logic [ADDR_W:0]      n_q, n_d;
  logic [RAM_WIDTH-1:0] cnt_q, cnt_d;
  logic                 fired_q, fired_d;
  logic [15:0]          pass_q, pass_d;
  entry_t               cur_q, cur_d;

  logic                 start_edge;
  logic [ADDR_W:0]      n_eff;
  logic [ADDR_W:0]      idx_inc;
  logic [RAM_WIDTH-1:0] dwell_eff;
  logic [15:0]          pass_inc;
  logic                 load_en;

`ifdef IND_PORT_SEQ_EXT_TRIG_EN
  logic trig_q;
  logic trig_edge;
  assign trig_edge = io_ext_trig & ~trig_q;
`endif

  // Table storage has no reset; only indices below DEPTH are ever written.
  always_ff @(posedge io_clk) begin
    if (io_wr_en && ({1'b0, io_wr_addr} < DEPTH_C))
      tbl_q[io_wr_addr] <= {io_wr_width, io_wr_delay, io_wr_repeat, io_wr_dwell};
  end

  assign start_edge = io_start & ~start_q;
  assign n_eff      = (io_num_entries > DEPTH_C) ? DEPTH_C : io_num_entries;
  assign idx_inc    = {1'b0, idx_q} + 1'b1;
  assign dwell_eff  = (cur_q.dwell == '0) ? CNT_ONE : cur_q.dwell;
  assign pass_inc   = (pass_q == 16'hFFFF) ? pass_q : pass_q + 16'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    fired_d = fired_q;
    pass_d  = pass_q;
    load_en = 1'b0;
    if (io_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            n_d     = n_eff;
            fired_d = 1'b0;
            if (n_eff != '0) begin
              state_d = S_LOAD;
              idx_d   = '0;
              load_en = 1'b1;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_LOAD: begin
`ifdef IND_PORT_SEQ_EXT_TRIG_EN
          state_d = S_ARM;
`else
          state_d = S_FIRE;
`endif
        end
`ifdef IND_PORT_SEQ_EXT_TRIG_EN
        S_ARM: if (trig_edge) state_d = S_FIRE;
`endif
        S_FIRE: begin
          cnt_d   = dwell_eff;
          fired_d = 1'b1;
          state_d = S_DWELL;
        end
        S_DWELL: begin
          if (cnt_q <= CNT_ONE) begin
            if (idx_inc < n_q) begin
              idx_d   = idx_q + 1'b1;
              load_en = 1'b1;
              state_d = S_LOAD;
            end else if (io_loop) begin
              idx_d   = '0;
              pass_d  = pass_inc;
              load_en = 1'b1;
              state_d = S_LOAD;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_DONE: begin
          if (fired_q) pass_d = pass_inc;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Config is captured on entry to LOAD so it is stable a full cycle before FIRE.
    cur_d = load_en ? tbl_q[idx_d] : cur_q;
  end

  always_ff @(posedge io_clk) begin
    if (!io_rst_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      idx_q   <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      fired_q <= 1'b0;
      pass_q  <= '0;
      cur_q   <= '0;
`ifdef IND_PORT_SEQ_EXT_TRIG_EN
      trig_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= io_start;
      idx_q   <= idx_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      fired_q <= fired_d;
      pass_q  <= pass_d;
      cur_q   <= cur_d;
`ifdef IND_PORT_SEQ_EXT_TRIG_EN
      trig_q  <= io_ext_trig;
`endif
    end
  end

  assign io_pulseEn    = (state_q == S_FIRE);
  assign io_done       = (state_q == S_DONE);
  assign io_busy       = (state_q != S_IDLE);
  assign io_pulseWidth = cur_q.width;
  assign io_trigDelay  = cur_q.delay;
  assign io_repeatCnt  = cur_q.rep;
  assign io_cur_idx    = idx_q;
  assign io_pass_cnt   = pass_q;

endmodule
